// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset main control FSM: sequences fetch/decode/execute/memory/write-back,
// stalls on the memory ready handshake, traps illegal opcodes and counts retired instructions.
module mc_control_unit #(
    parameter int ALU_OP_W     = 3,
    parameter int CNT_W        = 16,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          instr_op_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_o,
    output logic                ir_write_o,
    output logic                iord_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                mem_to_reg_o,
    output logic                reg_dst_o,
    output logic                reg_write_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          pc_source_o,
    output logic                illegal_o,
    output logic [3:0]          state_o,
    output logic [CNT_W-1:0]    retired_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic             isSlti_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instr_op_i)
                    OP_R:             state_d = S_R_EXEC;
                    OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    default:          state_d = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (instr_op_i == OP_LW)      state_d = S_MEM_RD;
                else if (instr_op_i == OP_SW) state_d = S_MEM_WR;
                else                          state_d = S_FETCH;
            end
            S_MEM_RD: state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB: retire = 1'b1;
            S_MEM_WR: begin
                state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
                retire  = mem_ready_i;
            end
            S_R_EXEC: state_d = S_R_WB;
            S_R_WB:   retire  = 1'b1;
            S_I_EXEC: state_d = S_I_WB;
            S_I_WB:   retire  = 1'b1;
            S_BRANCH: retire  = 1'b1;
            S_JUMP:   retire  = 1'b1;
            default:  state_d = S_FETCH;
        endcase
    end

    // The opcode is only guaranteed in DECODE, so remember addi vs slti for I_EXEC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            isSlti_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                isSlti_q <= (instr_op_i == OP_SLTI);
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    // Outputs are decoded from the state and forced low while reset is held.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        ir_write_o      = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = '0;
        pc_source_o     = 2'b00;
        illegal_o       = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: alu_src_b_o = 2'b11;
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEM_RD: begin
                    iord_o     = 1'b1;
                    mem_read_o = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEM_WR: begin
                    iord_o      = 1'b1;
                    mem_write_o = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_OP_W'(3'b010);
                end
                S_R_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = isSlti_q ? ALU_OP_W'(3'b111) : ALU_OP_W'(3'b100);
                end
                S_I_WB: reg_write_o = 1'b1;
                S_BRANCH: begin
                    alu_src_a_o     = 1'b1;
                    alu_op_o        = ALU_OP_W'(3'b101);
                    pc_write_cond_o = 1'b1;
                    pc_source_o     = 2'b01;
                end
                S_JUMP: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = 2'b10;
                end
                S_TRAP:  illegal_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o   = state_q;
    assign retired_o = retired_q;

endmodule
